// File: rtl/bus_master.sv
// 68030 bus initiator: wins the bus with BR/BG/BGACK, runs dynamically sized
// asynchronous cycles terminated by DSACK/BERR and returns data or error.
module bus_master #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [2:0] FC_CODE        = 3'b101
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        REQ,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic [31:0] REQ_WDATA,
    output logic        ACK,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        BR_n,
    input  logic        BG_n,
    output logic        BGACK_n,
    output logic        BUS_OE,
    output logic [31:0] A_OUT,
    output logic [2:0]  FC_OUT,
    output logic [1:0]  SIZ,
    output logic        RW,
    output logic        AS_n,
    output logic        DS_n,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic        DSACK0_n,
    input  logic        DSACK1_n,
    input  logic        BERR_n
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARB, ST_ADDR, ST_STRB, ST_WAIT, ST_LATCH, ST_IDLE1, ST_END
    } state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     rem_q, rem_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    acc_q, acc_d;
    logic [2:0]     port_q, port_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           br_n_q, br_n_d, bgack_n_q, bgack_n_d;
    logic           bus_oe_q, bus_oe_d, d_oe_q, d_oe_d;
    logic [31:0]    a_q, a_d, dout_q, dout_d, rdata_q, rdata_d;
    logic [2:0]     fc_q, fc_d;
    logic [1:0]     siz_q, siz_d;
    logic           rw_q, rw_d, as_n_q, as_n_d, ds_n_q, ds_n_d;
    logic           ack_q, ack_d, err_q, err_d;

    logic [7:0]     din_lane [4];
    logic [7:0]     pend [4];
    logic [7:0]     wlane [4];
    logic [2:0]     offs, span, n_bytes;
    logic [31:0]    acc_cap;
    logic           done, fail;

    // pend[j] is the j-th still-unsent operand byte, most significant first
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign din_lane[gi] = D_IN[31-8*gi -: 8];
            assign pend[gi] = (32'(rem_q) > gi)
                            ? 8'(wdata_q >> (8 * (32'(rem_q) - 1 - gi))) : 8'h00;
        end
    endgenerate

    always_comb begin
        offs = 3'd0;
        if (port_q == 3'd4)      offs = {1'b0, addr_q[1:0]};
        else if (port_q == 3'd2) offs = {2'b00, addr_q[0]};
        span    = port_q - offs;
        n_bytes = (rem_q < span) ? rem_q : span;
    end

    always_comb begin
        acc_cap = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < n_bytes)
                acc_cap = {acc_cap[23:0], din_lane[2'(offs + 3'(i))]};
        end
    end

    // Lane replication lets 8- and 16-bit ports find their bytes in place
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wlane[k] = 8'h00;
            if (2'(k) >= addr_q[1:0]) wlane[k] = pend[2'(2'(k) - addr_q[1:0])];
        end
        for (int k = 0; k < 2; k++) begin
            if (1'(k) >= addr_q[0]) wlane[k] = pend[2'(k) - {1'b0, addr_q[0]}];
        end
        if (addr_q[1:0] != 2'b00) wlane[0] = pend[0];
    end

    always_comb begin
        state_d = state_q;  we_d = we_q;      addr_d = addr_q;   rem_d = rem_q;
        wdata_d = wdata_q;  acc_d = acc_q;    port_d = port_q;   cnt_d = cnt_q;
        br_n_d = br_n_q;    bgack_n_d = bgack_n_q;  bus_oe_d = bus_oe_q;
        d_oe_d = d_oe_q;    a_d = a_q;        dout_d = dout_q;   rdata_d = rdata_q;
        fc_d = fc_q;        siz_d = siz_q;    rw_d = rw_q;       as_n_d = as_n_q;
        ds_n_d = ds_n_q;    ack_d = 1'b0;     err_d = err_q;
        done = 1'b0;        fail = 1'b0;
        case (state_q)
            ST_IDLE: if (REQ) begin
                we_d    = REQ_WE;
                addr_d  = REQ_ADDR;
                rem_d   = (REQ_SIZE == 2'b00) ? 3'd4 : {1'b0, REQ_SIZE};
                wdata_d = REQ_WDATA;
                acc_d   = 32'h0;
                br_n_d  = 1'b0;
                state_d = ST_ARB;
            end
            ST_ARB: if (!BG_n && DSACK0_n && DSACK1_n && BERR_n) begin
                bgack_n_d = 1'b0;
                br_n_d    = 1'b1;
                state_d   = ST_ADDR;
            end
            ST_ADDR: begin
                bus_oe_d = 1'b1;
                a_d      = addr_q;
                fc_d     = FC_CODE;
                rw_d     = ~we_q;
                siz_d    = rem_q[1:0];
                if (we_q) begin
                    d_oe_d = 1'b1;
                    dout_d = {wlane[0], wlane[1], wlane[2], wlane[3]};
                end
                state_d = ST_STRB;
            end
            ST_STRB: begin
                as_n_d  = 1'b0;
                if (!we_q) ds_n_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (we_q) ds_n_d = 1'b0;
                if (!BERR_n) begin
                    done = 1'b1;
                    fail = 1'b1;
                end else begin
                    case ({DSACK1_n, DSACK0_n})
                        2'b00: begin port_d = 3'd4; state_d = ST_LATCH; end
                        2'b01: begin port_d = 3'd2; state_d = ST_LATCH; end
                        2'b10: begin port_d = 3'd1; state_d = ST_LATCH; end
                        default: begin
                            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                                done = 1'b1;
                                fail = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                    endcase
                end
            end
            ST_LATCH: begin
                as_n_d = 1'b1;
                ds_n_d = 1'b1;
                if (!we_q) acc_d = acc_cap;
                addr_d = addr_q + 32'(n_bytes);
                rem_d  = rem_q - n_bytes;
                if (rem_q == n_bytes) done = 1'b1;
                else                  state_d = ST_IDLE1;
            end
            ST_IDLE1: state_d = ST_ADDR;
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (done) begin
            as_n_d    = 1'b1;
            ds_n_d    = 1'b1;
            d_oe_d    = 1'b0;
            bus_oe_d  = 1'b0;
            bgack_n_d = 1'b1;
            rw_d      = 1'b1;
            ack_d     = 1'b1;
            err_d     = fail;
            rdata_d   = fail ? 32'h0 : (we_q ? acc_q : acc_cap);
            state_d   = ST_END;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;  we_q <= 1'b0;     addr_q <= '0;     rem_q <= '0;
            wdata_q <= '0;       acc_q <= '0;      port_q <= '0;     cnt_q <= '0;
            br_n_q <= 1'b1;      bgack_n_q <= 1'b1; bus_oe_q <= 1'b0; d_oe_q <= 1'b0;
            a_q <= '0;           dout_q <= '0;     rdata_q <= '0;    fc_q <= '0;
            siz_q <= '0;         rw_q <= 1'b1;     as_n_q <= 1'b1;   ds_n_q <= 1'b1;
            ack_q <= 1'b0;       err_q <= 1'b0;
        end else begin
            state_q <= state_d;  we_q <= we_d;     addr_q <= addr_d; rem_q <= rem_d;
            wdata_q <= wdata_d;  acc_q <= acc_d;   port_q <= port_d; cnt_q <= cnt_d;
            br_n_q <= br_n_d;    bgack_n_q <= bgack_n_d; bus_oe_q <= bus_oe_d;
            d_oe_q <= d_oe_d;    a_q <= a_d;       dout_q <= dout_d; rdata_q <= rdata_d;
            fc_q <= fc_d;        siz_q <= siz_d;   rw_q <= rw_d;     as_n_q <= as_n_d;
            ds_n_q <= ds_n_d;    ack_q <= ack_d;   err_q <= err_d;
        end
    end

    assign ACK     = ack_q;
    assign RDATA   = rdata_q;
    assign ERR     = err_q;
    assign BR_n    = br_n_q;
    assign BGACK_n = bgack_n_q;
    assign BUS_OE  = bus_oe_q;
    assign A_OUT   = a_q;
    assign FC_OUT  = fc_q;
    assign SIZ     = siz_q;
    assign RW      = rw_q;
    assign AS_n    = as_n_q;
    assign DS_n    = ds_n_q;
    assign D_OUT   = dout_q;
    assign D_OE    = d_oe_q;

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Single-channel 68030-bus initiator (DMA/bus-master side) for the Mackerel-30 board.
- Takes a simple request from an internal engine (IDE DMA, memory test) and wins the bus via BR/BG/BGACK.
- Runs asynchronous 68030 bus cycles terminated by the system controller's DSACK/BERR, with dynamic bus sizing.
- Returns read data or an error status to the engine.

Parameters:
- TIMEOUT_CYCLES, 64, wait-state clocks allowed before a cycle is aborted with error.
- FC_CODE, 3'b101, function code driven during owned cycles (supervisor data).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_n  input  1  asynchronous active-low reset.
- REQ  input  1  request strobe; held until ACK.
- REQ_WE  input  1  1 = write, 0 = read.
- REQ_ADDR  input  32  byte address.
- REQ_SIZE  input  2  operand size: 01 byte, 10 word, 00 long.
- REQ_WDATA  input  32  write operand, right-justified.
- ACK  output  1  one-cycle completion pulse.
- RDATA  output  32  read operand, right-justified; valid with ACK.
- ERR  output  1  valid with ACK; 1 = BERR or timeout.
- BR_n  output  1  bus request.
- BG_n  input  1  bus grant.
- BGACK_n  output  1  bus grant acknowledge.
- BUS_OE  output  1  enables the A/FC/SIZ/RW/AS/DS drivers.
- A_OUT  output  32  address.
- FC_OUT  output  3  function code.
- SIZ  output  2  {SIZ1,SIZ0}.
- RW  output  1  1 = read.
- AS_n  output  1  address strobe.
- DS_n  output  1  data strobe.
- D_OUT  output  32  write data.
- D_OE  output  1  data bus driver enable.
- D_IN  input  32  read data bus.
- DSACK0_n  input  1  data transfer/size acknowledge bit 0.
- DSACK1_n  input  1  data transfer/size acknowledge bit 1.
- BERR_n  input  1  bus error.

Behaviour:
- Reset (async, any state): BR_n=1, BGACK_n=1, AS_n=1, DS_n=1, RW=1, BUS_OE=0, D_OE=0, ACK=0, ERR=0, RDATA=0, A_OUT=0, SIZ=00, FC_OUT=0, D_OUT=0, state=IDLE. No partial cycle resumes after reset.
- IDLE: when REQ=1, latch WE/ADDR/SIZE/WDATA. Set remaining count: 1/2/4 bytes. Set BR_n=0. Go ARB.
- ARB: wait for BG_n=0 with DSACK0_n=1, DSACK1_n=1 and BERR_n=1 sampled. Then BGACK_n=0, BR_n=1, go S_ADDR.
- S_ADDR: BUS_OE=1. Drive A_OUT=current address, FC_OUT=FC_CODE, RW=~WE. SIZ = remaining count (4→00, 3→11, 2→10, 1→01). For writes, D_OE=1 and D_OUT loaded. Go S_STRB.
- S_STRB: AS_n=0. For reads DS_n=0 in the same cycle; for writes DS_n=0 one cycle later. Timeout counter cleared. Go WAIT.
- WAIT: sample DSACK/BERR every edge.
  - BERR_n=0 takes priority over DSACK; it sets the error flag and goes END.
  - Port size from DSACK1_n,DSACK0_n: 00 → 32-bit, 01 → 16-bit, 10 → 8-bit. Go S_LATCH.
  - Counter reaching TIMEOUT_CYCLES sets the error flag and goes END.
- S_LATCH: one clock after DSACK is sampled, capture read bytes. Negate AS_n/DS_n.
  - n = min(remaining, port_bytes − (addr mod port_bytes)).
  - Advance address by n; remaining −= n.
  - If remaining>0, go S_IDLE1 (one clock with AS_n high), then S_ADDR. Otherwise go END.
- Read byte lanes: 32-bit port uses lanes addr[1:0]+i; 16-bit port uses lanes addr[0]+i; 8-bit port uses lane 0 (lane 0 = D31:24). Bytes accumulate MSB-first; the final operand is right-justified.
- Write lanes, MC68030 convention:
  - Next pending byte goes on lane addr[1:0], then following bytes on following lanes.
  - D31:16 also carries the pending bytes at lane addr[0] within the upper half.
  - D31:24 also carries the first pending byte when addr[1:0]≠0.
- END:
  - Negate AS_n/DS_n, D_OE=0, BUS_OE=0, BGACK_n=1.
  - Pulse ACK=1 for one clock with RDATA/ERR. ERR stays valid until the next ACK.
  - Return to IDLE. A new REQ is accepted no earlier than the clock after ACK.
- Errors/timeouts abort all remaining sub-cycles. RDATA is then undefined except that it reads 0 on error.
- BG_n negated mid-transfer is ignored; the bus is held (BGACK_n=0) until END.
- DSACK asserted in S_ADDR/S_STRB is ignored; sampling starts in WAIT.

Test Plan:
- Long read, 32-bit port: REQ_ADDR=0x80000000, D_IN=0x11223344, DSACK=00 on 3rd WAIT clock → one cycle, SIZ=00, ACK with RDATA=0x11223344, ERR=0.
- Long read, 8-bit port: REQ_ADDR=0xE0000000, DSACK=10, D31:24 = 11,22,33,44 → four cycles with A=…0..3, SIZ=00,11,10,01, RDATA=0x11223344.
- Misaligned word write, 16-bit port: REQ_ADDR=0xF0010001, WDATA=0xABCD, DSACK=01.
  - Cycle 1: A=…1, SIZ=10, D23:16=0xAB.
  - Cycle 2: A=…2, SIZ=01, D31:24=0xCD.
  - ACK, ERR=0.
- Timeout: TIMEOUT_CYCLES=16, no DSACK → AS_n negates 16 clocks after WAIT entry, ACK with ERR=1, BGACK_n=1. BERR_n=0 in WAIT → same, immediate.
- Arbitration: BG_n held high 10 clocks → BR_n=0, AS_n stays 1. BG_n low → BGACK_n=0 and BR_n=1 next clock, AS_n=0 two clocks later.
- Reset mid-cycle: RST_n=0 during WAIT → AS_n, DS_n, BR_n, BGACK_n=1 and BUS_OE=0 immediately, no ACK. After release, IDLE accepts a new REQ.
